display_scheduler: RTL and testbench

- Time-shares the two-digit seven-segment readout between up to NUM_SRC value producers, e.g. ratio, stroke rate and split.
- Round-robin selection of valid sources, with a programmable dwell time per source.
- Latches the selected value, clamps it to 0..99 and splits it into tens/ones with an iterative subtract-by-10 converter, so no combinational divider is needed.
- Outputs feed the existing 4-bit-per-digit seven-segment decoder.

---
 rtl/display_scheduler_pkg.sv | 17 +
 rtl/display_scheduler_bcd2_iter.sv | 64 ++++++
 rtl/display_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_display_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the two-digit display scheduler.
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_CONVERT = 2'd2,
    ST_SHOW    = 2'd3
  } state_e;

  localparam int DISPLAY_MAX = 99;
  localparam int RADIX       = 10;

  // One BCD digit as consumed by the seven-segment decoder.
  typedef logic [3:0] digit_t;

endpackage

// File: rtl/display_scheduler_bcd2_iter.sv
// Iterative two-digit binary-to-BCD converter: subtracts RADIX once per cycle
// until the remainder drops below RADIX. Input must already be clamped to 0..99.
module bcd2_iter
  import display_scheduler_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [6:0] val_i,
  output logic       busy_o,
  output logic       done_o,
  output digit_t     tens_o,
  output digit_t     ones_o
);

  logic [6:0] rem_q, rem_d;
  digit_t     acc_q, acc_d;
  logic       busy_q, busy_d;
  logic       ge_radix;

  assign ge_radix = (rem_q >= 7'(RADIX));

  // Next-state: load on start, one subtract step per cycle while busy.
  always_comb begin
    rem_d  = rem_q;
    acc_d  = acc_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = val_i;
      acc_d  = '0;
      busy_d = 1'b1;
    end else if (abort_i) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (ge_radix) begin
        rem_d = rem_q - 7'(RADIX);
        acc_d = acc_q + 4'd1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // Converter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      acc_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      acc_q  <= acc_d;
      busy_q <= busy_d;
    end
  end

  // done is valid for the single cycle where the remainder is final.
  assign busy_o = busy_q;
  assign done_o = busy_q && !ge_radix;
  assign tens_o = acc_q;
  assign ones_o = rem_q[3:0];

endmodule

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of a two-digit readout between NUM_SRC sources,
// with per-source dwell, clamp to 0..99 and iterative BCD conversion.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int NUM_SRC      = 3,
  parameter int VAL_W        = 32,
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_SRC*VAL_W-1:0] src_value,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic                     hold,
  output logic [3:0]               tens,
  output logic [3:0]               ones,
  output logic                     digits_valid,
  output logic [1:0]               src_sel,
  output logic                     overflow
);

  state_e           state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_t           tens_q, tens_d, ones_q, ones_d;
  logic             ovf_q, ovf_d, ovf_pend_q, ovf_pend_d;
  logic             dv_q, dv_d;

  logic [VAL_W-1:0] cur_val;
  logic             cur_valid;
  logic             over_max;
  logic [6:0]       conv_val;
  logic [1:0]       sel_inc;
  logic [1:0]       arb_ptr, arb_idx, arb_scan;
  logic             arb_found;
  logic             conv_start, conv_abort, conv_busy, conv_done;
  digit_t           conv_tens, conv_ones;

  // Value and request of the currently selected source.
  always_comb begin
    cur_val   = '0;
    cur_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_q == 2'(i)) begin
        cur_val   = src_value[i*VAL_W +: VAL_W];
        cur_valid = src_valid[i];
      end
    end
  end

  assign over_max = (cur_val > VAL_W'(DISPLAY_MAX));
  assign conv_val = over_max ? 7'(DISPLAY_MAX) : cur_val[6:0];
  assign sel_inc  = (sel_q == 2'(NUM_SRC-1)) ? 2'd0 : sel_q + 2'd1;

  // On dwell expiry the search starts just past the current source.
  assign arb_ptr = (state_q == ST_SHOW) ? sel_inc : rr_q;

  // First valid source at or after arb_ptr, wrapping; scanned backwards so
  // the nearest hit is the last one written.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_scan  = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      arb_scan = 2'((int'(arb_ptr) + k) % NUM_SRC);
      if (src_valid[arb_scan]) begin
        arb_found = 1'b1;
        arb_idx   = arb_scan;
      end
    end
  end

  bcd2_iter u_bcd (
    .clock   (clock),
    .reset   (reset),
    .start_i (conv_start),
    .abort_i (conv_abort),
    .val_i   (conv_val),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .tens_o  (conv_tens),
    .ones_o  (conv_ones)
  );

  // Scheduler FSM: arbitration, latch, conversion handshake and dwell.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    dv_d       = dv_q;
    conv_start = 1'b0;
    conv_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dv_d = 1'b0;
        if (arb_found) begin
          sel_d   = arb_idx;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        conv_start = 1'b1;
        ovf_pend_d = over_max;
        state_d    = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (!cur_valid) begin
          conv_abort = 1'b1;
          dv_d       = 1'b0;
          rr_d       = sel_inc;
          state_d    = ST_IDLE;
        end else if (conv_busy && conv_done) begin
          tens_d  = conv_tens;
          ones_d  = conv_ones;
          ovf_d   = ovf_pend_q;
          dv_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!cur_valid) begin
          dv_d    = 1'b0;
          rr_d    = sel_inc;
          state_d = ST_IDLE;
        end else if (!hold) begin
          if (cnt_q == CNT_W'(DWELL_CYCLES-1)) begin
            rr_d = sel_inc;
            if (arb_found) begin
              sel_d = arb_idx;
              // A same-source refresh keeps the old digits on display.
              if (arb_idx != sel_q) dv_d = 1'b0;
              state_d = ST_LATCH;
            end else begin
              dv_d    = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
      dv_q       <= dv_d;
    end
  end

  assign tens         = tens_q;
  assign ones         = ones_q;
  assign digits_valid = dv_q;
  assign src_sel      = sel_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with a short dwell.
module tb_display_scheduler;
  localparam int NUM_SRC = 3;
  localparam int VAL_W   = 32;
  localparam int DWELL   = 8;
  localparam int CNT_W   = 4;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_SRC*VAL_W-1:0] src_value;
  logic [NUM_SRC-1:0]       src_valid;
  logic                     hold;
  logic [3:0]               tens, ones;
  logic                     digits_valid;
  logic [1:0]               src_sel;
  logic                     overflow;

  always #5 clock = ~clock;

  display_scheduler #(
    .NUM_SRC(NUM_SRC), .VAL_W(VAL_W), .DWELL_CYCLES(DWELL), .CNT_W(CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .src_value    (src_value),
    .src_valid    (src_valid),
    .hold         (hold),
    .tens         (tens),
    .ones         (ones),
    .digits_valid (digits_valid),
    .src_sel      (src_sel),
    .overflow     (overflow)
  );

  // gap: cycles since the previous display event, -1 = not checked
  typedef struct {
    logic [1:0] sel;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
    int         gap;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int ev_cnt = 0, ev_goal = 0, cyc = 0;

  logic        m_pdv = 1'b0;
  logic [10:0] m_pv = '0;
  logic [10:0] m_cur;
  int          m_last = 0, m_gap;
  exp_t        m_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int sel, input int t, input int o, input int ovf, input int gap);
    exp_t e;
    e.sel = 2'(sel); e.tens = 4'(t); e.ones = 4'(o); e.ovf = 1'(ovf); e.gap = gap;
    q.push_back(e);
  endtask

  task automatic wait_ev();
    ev_goal++;
    for (int i = 0; i < 300; i++) begin
      if (ev_cnt >= ev_goal) return;
      @(negedge clock); #2;
    end
    checks++; errors++;
    $display("FAIL timeout waiting for display event %0d", ev_goal);
  endtask

  task automatic set_val(input int i, input logic [VAL_W-1:0] v);
    src_value[i*VAL_W +: VAL_W] = v;
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1; src_valid = '0; hold = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: a display event is digits_valid rising, or shown content changing while valid.
  initial forever begin
    @(negedge clock);
    m_cur = {src_sel, tens, ones, overflow};
    if (!reset && digits_valid === 1'b1 && (!m_pdv || m_cur != m_pv)) begin
      ev_cnt++;
      m_gap  = cyc - m_last;
      m_last = cyc;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: sel=%0d tens=%0d ones=%0d ovf=%0d", src_sel, tens, ones, overflow);
      end else begin
        m_e = q.pop_front();
        if (src_sel !== m_e.sel || tens !== m_e.tens || ones !== m_e.ones || overflow !== m_e.ovf ||
            (m_e.gap >= 0 && m_gap != m_e.gap)) begin
          errors++;
          $display("FAIL event%0d: got sel=%0d tens=%0d ones=%0d ovf=%0d gap=%0d, expected sel=%0d tens=%0d ones=%0d ovf=%0d gap=%0d",
                   ev_cnt, src_sel, tens, ones, overflow, m_gap, m_e.sel, m_e.tens, m_e.ones, m_e.ovf, m_e.gap);
        end
      end
    end
    m_pdv = (digits_valid === 1'b1);
    m_pv  = m_cur;
  end

  initial begin
    int n;
    logic steady;
    reset = 1'b1; src_valid = '0; hold = 1'b0; src_value = '0;

    // Reset state
    @(negedge clock);
    chk("rst_tens", int'(tens), 0);
    chk("rst_ones", int'(ones), 0);
    chk("rst_dv", int'(digits_valid), 0);
    chk("rst_sel", int'(src_sel), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Single source 47: digits 6 cycles after LATCH entry
    @(negedge clock);
    reset = 1'b0;
    set_val(0, 47);
    src_valid = 3'b001;
    expect_ev(0, 4, 7, 0, -1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (digits_valid !== 1'b1 && n < 30);
    chk("latency_47", n, 7);
    wait_ev();

    // Round robin 0->1->2->0; gap = 8 dwell + conversion latency of next source
    reset_dut();
    set_val(0, 12); set_val(1, 5); set_val(2, 99);
    src_valid = 3'b111;
    expect_ev(0, 1, 2, 0, -1);
    expect_ev(1, 0, 5, 0, 10);
    expect_ev(2, 9, 9, 0, 19);
    expect_ev(0, 1, 2, 0, 11);
    repeat (4) wait_ev();

    // Clamp with overflow, then same-source refresh to 30
    reset_dut();
    set_val(0, 1234);
    src_valid = 3'b001;
    expect_ev(0, 9, 9, 1, -1);
    expect_ev(0, 3, 0, 0, 13);
    wait_ev();
    set_val(0, 30);
    steady = 1'b1;
    repeat (14) begin
      @(negedge clock);
      if (digits_valid !== 1'b1) steady = 1'b0;
    end
    chk("dv_steady_refresh", int'(steady), 1);
    wait_ev();

    // Hold freezes dwell for 20 cycles; then abort paths
    reset_dut();
    set_val(0, 12); set_val(1, 5);
    src_valid = 3'b011;
    expect_ev(0, 1, 2, 0, -1);
    expect_ev(1, 0, 5, 0, 30);
    expect_ev(0, 1, 2, 0, 5);
    wait_ev();
    repeat (3) @(negedge clock);
    hold = 1'b1;
    repeat (20) @(negedge clock);
    chk("hold_sel", int'(src_sel), 0);
    chk("hold_dv", int'(digits_valid), 1);
    hold = 1'b0;
    wait_ev();
    src_valid = 3'b001;
    @(negedge clock);
    chk("abort_dv", int'(digits_valid), 0);
    wait_ev();
    src_valid = 3'b000;
    @(negedge clock);
    chk("drop_all_dv", int'(digits_valid), 0);
    repeat (10) @(negedge clock);
    chk("idle_dv", int'(digits_valid), 0);
    chk("idle_sel", int'(src_sel), 0);

    // Asynchronous reset during a refresh conversion
    reset_dut();
    set_val(1, 99);
    src_valid = 3'b010;
    expect_ev(1, 9, 9, 0, -1);
    wait_ev();
    repeat (12) @(negedge clock);
    chk("reconv_dv", int'(digits_valid), 1);
    chk("reconv_tens", int'(tens), 9);
    #2 reset = 1'b1;
    #1;
    chk("async_tens", int'(tens), 0);
    chk("async_ones", int'(ones), 0);
    chk("async_dv", int'(digits_valid), 0);
    chk("async_sel", int'(src_sel), 0);
    chk("async_ovf", int'(overflow), 0);
    expect_ev(1, 9, 9, 0, -1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_ev();

    repeat (3) @(negedge clock);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
